// File: rtl/psram_pkg.sv
// Shared definitions for the PSRAM arbiter: FSM state encoding, grant one-hot
// constants and default bus widths.
package psram_pkg;
    localparam int PSRAM_ADDR_W = 23;
    localparam int PSRAM_DATA_W = 16;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_GNT_VID  = 2'd1,
        ST_GNT_HOST = 2'd2,
        ST_RELEASE  = 2'd3
    } arb_state_e;

    localparam logic [1:0] GNT_NONE    = 2'b00;
    localparam logic [1:0] GNT_VID_OH  = 2'b01;
    localparam logic [1:0] GNT_HOST_OH = 2'b10;
endpackage

// File: rtl/psram_arb_starve.sv
// Saturating 8-bit host starvation counter with its priority-limit compare.
module psram_arb_starve #(
    parameter int STARVE_LIMIT = 200
) (
    input  logic clk,
    input  logic reset_n,
    input  logic i_inc,
    input  logic i_clr,
    output logic o_starved
);
    logic [7:0] r_cnt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            r_cnt <= '0;
        else if (i_clr)
            r_cnt <= '0;
        else if (i_inc && r_cnt != 8'hFF)
            r_cnt <= r_cnt + 8'd1;
    end

    assign o_starved = (int'(r_cnt) >= STARVE_LIMIT);
endmodule

// File: rtl/psram_arbiter.sv
// Two-requester (video/host) PSRAM arbiter, non-preemptive, video priority with
// host anti-starvation. Define PSRAM_ARB_TIMEOUT_EN to bound grant length.
module psram_arbiter
    import psram_pkg::*;
#(
    parameter int ADDR_W         = PSRAM_ADDR_W,
    parameter int DATA_W         = PSRAM_DATA_W,
    parameter int STARVE_LIMIT   = 200,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              vid_req,
    input  logic              vid_rd,
    input  logic              vid_burst,
    input  logic [ADDR_W-1:0] vid_addr,
    output logic              vid_op_begun,
    output logic              vid_data_ok,
    input  logic              host_req,
    input  logic              host_rd,
    input  logic              host_wr,
    input  logic [ADDR_W-1:0] host_addr,
    input  logic [DATA_W-1:0] host_wdata,
    output logic              host_op_begun,
    output logic              host_data_ok,
    output logic              mem_rd,
    output logic              mem_wr,
    output logic              mem_burst,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_op_begun,
    input  logic              mem_data_ok,
    input  logic              mem_ctrlr_good,
    output logic [1:0]        grant,
    output logic              timeout_err
);
    arb_state_e r_state, w_next;
    logic       w_starved, w_tmo, w_vid_blk, w_host_blk, w_vid_ok, w_host_ok;

    psram_arb_starve #(.STARVE_LIMIT(STARVE_LIMIT)) u_starve (
        .clk       (clk),
        .reset_n   (reset_n),
        .i_inc     (host_req && r_state != ST_GNT_HOST),
        .i_clr     (w_next == ST_GNT_HOST && r_state != ST_GNT_HOST),
        .o_starved (w_starved)
    );

`ifdef PSRAM_ARB_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] r_gnt_cnt;
    logic          r_vid_blk, r_host_blk, r_timeout_err;
    logic          w_in_gnt, w_cur_req;

    assign w_in_gnt  = (r_state == ST_GNT_VID) || (r_state == ST_GNT_HOST);
    assign w_cur_req = (r_state == ST_GNT_VID) ? vid_req : host_req;
    // A requester that drops its req on the last cycle releases normally.
    assign w_tmo     = w_in_gnt && w_cur_req && (r_gnt_cnt == TW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_gnt_cnt     <= '0;
            r_vid_blk     <= 1'b0;
            r_host_blk    <= 1'b0;
            r_timeout_err <= 1'b0;
        end else begin
            r_gnt_cnt     <= (w_in_gnt && w_next == r_state) ? r_gnt_cnt + 1'b1 : '0;
            r_timeout_err <= w_tmo;
            if (!vid_req)
                r_vid_blk <= 1'b0;
            else if (w_tmo && r_state == ST_GNT_VID)
                r_vid_blk <= 1'b1;
            if (!host_req)
                r_host_blk <= 1'b0;
            else if (w_tmo && r_state == ST_GNT_HOST)
                r_host_blk <= 1'b1;
        end
    end

    assign w_vid_blk   = r_vid_blk;
    assign w_host_blk  = r_host_blk;
    assign timeout_err = r_timeout_err;
`else
    assign w_tmo       = (TIMEOUT_CYCLES < 0);
    assign w_vid_blk   = 1'b0;
    assign w_host_blk  = 1'b0;
    assign timeout_err = 1'b0;
`endif

    assign w_vid_ok  = vid_req && !w_vid_blk;
    assign w_host_ok = host_req && !w_host_blk;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            r_state <= ST_IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            ST_IDLE:
                if (mem_ctrlr_good && (w_vid_ok || w_host_ok))
                    w_next = (w_host_ok && (!w_vid_ok || w_starved)) ? ST_GNT_HOST : ST_GNT_VID;
            ST_GNT_VID:  if (!vid_req || w_tmo)  w_next = ST_RELEASE;
            ST_GNT_HOST: if (!host_req || w_tmo) w_next = ST_RELEASE;
            default:     w_next = ST_IDLE;
        endcase
    end

    always_comb begin
        grant         = GNT_NONE;
        mem_rd        = 1'b0;
        mem_wr        = 1'b0;
        mem_burst     = 1'b0;
        mem_addr      = '0;
        mem_wdata     = '0;
        vid_op_begun  = 1'b0;
        vid_data_ok   = 1'b0;
        host_op_begun = 1'b0;
        host_data_ok  = 1'b0;
        unique case (r_state)
            ST_GNT_VID: begin
                grant        = GNT_VID_OH;
                mem_rd       = vid_rd;
                mem_burst    = vid_burst;
                mem_addr     = vid_addr;
                vid_op_begun = mem_op_begun;
                vid_data_ok  = mem_data_ok;
            end
            ST_GNT_HOST: begin
                grant         = GNT_HOST_OH;
                mem_rd        = host_rd;
                mem_wr        = host_wr;
                mem_addr      = host_addr;
                mem_wdata     = host_wdata;
                host_op_begun = mem_op_begun;
                host_data_ok  = mem_data_ok;
            end
            default: ;
        endcase
    end
endmodule

// File: tb/tb_psram_arbiter.sv
// Self-checking bench for psram_arbiter: directed vector table, hand sequences
// and randomized traffic against an owner-based behavioural model.
module tb_psram_arbiter;
    localparam int AW = 23, DW = 16, STARVE = 4, TMO = 16;
`ifdef PSRAM_ARB_TIMEOUT_EN
    localparam bit TMO_EN = 1'b1;
    localparam int BURST  = 12;
`else
    localparam bit TMO_EN = 1'b0;
    localparam int BURST  = 128;
`endif

    logic clk = 1'b0, reset_n = 1'b0;
    logic vid_req = 0, vid_rd = 0, vid_burst = 0, host_req = 0, host_rd = 0, host_wr = 0;
    logic [AW-1:0] vid_addr = '0, host_addr = '0;
    logic [DW-1:0] host_wdata = '0;
    logic mem_op_begun = 0, mem_data_ok = 0, mem_ctrlr_good = 1;
    logic vid_op_begun, vid_data_ok, host_op_begun, host_data_ok;
    logic mem_rd, mem_wr, mem_burst, timeout_err;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [1:0] grant;

    psram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_LIMIT(STARVE), .TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .reset_n(reset_n),
        .vid_req(vid_req), .vid_rd(vid_rd), .vid_burst(vid_burst), .vid_addr(vid_addr),
        .vid_op_begun(vid_op_begun), .vid_data_ok(vid_data_ok),
        .host_req(host_req), .host_rd(host_rd), .host_wr(host_wr), .host_addr(host_addr),
        .host_wdata(host_wdata), .host_op_begun(host_op_begun), .host_data_ok(host_data_ok),
        .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_burst(mem_burst), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_op_begun(mem_op_begun), .mem_data_ok(mem_data_ok),
        .mem_ctrlr_good(mem_ctrlr_good), .grant(grant), .timeout_err(timeout_err));

    always #5 clk = ~clk;

    int n_checks = 0, n_fail = 0;

    // Model: who owns the memory (0 none, 1 video, 2 host), a one-cycle
    // cool-down after any grant, host wait length and per-requester lockout.
    int m_own, m_wait, m_held;
    bit m_rel, m_vblk, m_hblk, m_terr;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_own = 0; m_wait = 0; m_held = 0; m_rel = 0; m_vblk = 0; m_hblk = 0; m_terr = 0;
    endtask

    task automatic model_step();
        int nown; bit nrel, nterr, req;
        nown = m_own; nrel = 0; nterr = 0;
        if (m_rel) nown = 0;
        else if (m_own == 0) begin
            if (mem_ctrlr_good) begin
                if (host_req && !m_hblk && (!(vid_req && !m_vblk) || m_wait >= STARVE)) nown = 2;
                else if (vid_req && !m_vblk) nown = 1;
            end
        end else begin
            req = (m_own == 1) ? vid_req : host_req;
            m_held++;
            if (!req) begin nown = 0; nrel = 1; end
            else if (TMO_EN && m_held == TMO) begin
                nown = 0; nrel = 1; nterr = 1;
                if (m_own == 1) m_vblk = 1; else m_hblk = 1;
            end
        end
        if (nrel) m_held = 0;
        if (!vid_req) m_vblk = 0;
        if (!host_req) m_hblk = 0;
        if (nown == 2 && m_own != 2) m_wait = 0;
        else if (host_req && m_own != 2 && m_wait < 255) m_wait++;
        m_own = nown; m_rel = nrel; m_terr = nterr;
    endtask

    task automatic step();
        model_step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check_all(input string tag);
        bit v, h;
        v = (m_own == 1); h = (m_own == 2);
        chk({tag, ".grant"}, 64'(grant), 64'({h, v}));
        chk({tag, ".mem"}, 64'({mem_rd, mem_wr, mem_burst, mem_addr, mem_wdata}),
            64'({v ? vid_rd : (h & host_rd), h & host_wr, v & vid_burst,
                 v ? vid_addr : (h ? host_addr : '0), h ? host_wdata : '0}));
        chk({tag, ".hs"}, 64'({vid_op_begun, vid_data_ok, host_op_begun, host_data_ok}),
            64'({v & mem_op_begun, v & mem_data_ok, h & mem_op_begun, h & mem_data_ok}));
        chk({tag, ".terr"}, 64'(timeout_err), 64'(m_terr));
    endtask

    task automatic idle_inputs();
        vid_req = 0; vid_rd = 0; vid_burst = 0; host_req = 0; host_rd = 0; host_wr = 0;
        mem_op_begun = 0; mem_data_ok = 0; mem_ctrlr_good = 1;
    endtask

    task automatic do_reset();
        reset_n = 0; model_reset();
        @(posedge clk); @(negedge clk);
        idle_inputs();
        reset_n = 1;
    endtask

    typedef struct { logic vr, hr, hw, good; logic [1:0] eg; logic ewr; } vec_t;
    vec_t tbl[15];

    initial begin
        int n, cnt; bit seen;
        tbl = '{
            '{0,0,0,1,2'b00,0}, '{1,1,0,1,2'b01,0}, '{1,1,1,1,2'b01,0}, '{0,1,0,1,2'b00,0},
            '{0,1,0,1,2'b00,0}, '{0,1,1,1,2'b10,1}, '{1,1,1,1,2'b10,1}, '{1,0,0,1,2'b00,0},
            '{1,0,1,1,2'b00,0}, '{1,0,1,1,2'b01,0}, '{0,0,0,1,2'b00,0}, '{1,0,0,0,2'b00,0},
            '{1,0,0,0,2'b00,0}, '{1,0,0,1,2'b01,0}, '{1,0,0,0,2'b01,0}};
        @(negedge clk);
        do_reset();
        chk("reset.grant", 64'(grant), 64'd0);
        chk("reset.outs", 64'({mem_rd, mem_wr, mem_addr, timeout_err}), 64'd0);

        // Directed arbitration table
        host_addr = 23'h00ABC; host_wdata = 16'h1234; vid_addr = 23'h00555;
        for (int i = 0; i < 15; i++) begin
            vid_req = tbl[i].vr; host_req = tbl[i].hr; host_wr = tbl[i].hw;
            mem_ctrlr_good = tbl[i].good;
            step();
            chk($sformatf("tbl%0d.grant", i), 64'(grant), 64'(tbl[i].eg));
            chk($sformatf("tbl%0d.mem_wr", i), 64'(mem_wr), 64'(tbl[i].ewr));
            check_all($sformatf("tbl%0d", i));
        end

        // Video burst: request at cycle 5, grant one cycle later
        do_reset();
        for (int i = 0; i < 5; i++) step();
        vid_req = 1; vid_rd = 1; vid_burst = 1;
        step();
        chk("vid.grant", 64'(grant), 64'(2'b01));
        for (int i = 0; i < BURST; i++) begin
            vid_addr = AW'($urandom); mem_data_ok = $urandom_range(0, 1);
            mem_op_begun = (i == 0);
            #1 check_all($sformatf("vidburst%0d", i));
            step();
        end
        vid_req = 0; vid_rd = 0; vid_burst = 0; mem_data_ok = 0;
        step(); chk("vid.release", 64'(grant), 64'd0); check_all("vid.rel");
        step(); chk("vid.idle", 64'(grant), 64'd0);

        // Host write routing
        do_reset();
        host_req = 1; host_wr = 1; host_addr = 23'h12345; host_wdata = 16'hBEEF;
        mem_op_begun = 1; mem_data_ok = 1;
        step();
        chk("hwr.mem_wr", 64'(mem_wr), 64'd1);
        chk("hwr.addr", 64'(mem_addr), 64'h12345);
        chk("hwr.wdata", 64'(mem_wdata), 64'hBEEF);
        chk("hwr.vid_hs", 64'({vid_op_begun, vid_data_ok}), 64'd0);
        chk("hwr.host_hs", 64'({host_op_begun, host_data_ok}), 64'b11);

        // Starvation: video re-requests immediately after each release
        do_reset();
        host_req = 1; vid_req = 1; seen = 0; cnt = 0;
        for (int i = 0; i < 40 && !seen; i++) begin
            if (cnt == 3) begin vid_req = 0; cnt = 0; end
            else begin vid_req = 1; if (grant == 2'b01) cnt++; end
            step(); check_all($sformatf("starve%0d", i));
            if (grant == 2'b10 && vid_req) seen = 1;
        end
        chk("starve.host_won", 64'(seen), 64'd1);

        // Asynchronous reset mid video grant
        do_reset();
        vid_req = 1; vid_rd = 1; vid_burst = 1; mem_op_begun = 1; mem_data_ok = 1;
        step(); step();
        chk("rstmid.pre", 64'(grant), 64'(2'b01));
        #2 reset_n = 0; model_reset();
        #1;
        chk("rstmid.outs", 64'({grant, mem_rd, mem_burst, mem_addr, vid_op_begun, vid_data_ok, timeout_err}), 64'd0);
        @(posedge clk); @(negedge clk);
        mem_ctrlr_good = 0; host_req = 1; reset_n = 1;
        for (int i = 0; i < 3; i++) begin
            step(); chk($sformatf("nogood%0d", i), 64'(grant), 64'd0);
        end

        // Long host hold: forced release with timeout build, unbounded otherwise
        do_reset();
        idle_inputs(); host_req = 1;
        step();
        n = 0; cnt = 0;
        for (int i = 0; i < 40; i++) begin
            if (grant == 2'b10) n++;
            if (timeout_err) cnt++;
            check_all($sformatf("tmo%0d", i));
            step();
        end
        chk("tmo.grant_cycles", 64'(n), TMO_EN ? 64'(TMO) : 64'd40);
        chk("tmo.err_pulses", 64'(cnt), TMO_EN ? 64'd1 : 64'd0);
        host_req = 0; step(); check_all("tmo.drop");
        host_req = 1; step(); step();
        chk("tmo.regrant", 64'(grant), 64'(2'b10));

        // Randomized traffic against the model
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 7) == 0) vid_req = ~vid_req;
            if ($urandom_range(0, 7) == 0) host_req = ~host_req;
            mem_ctrlr_good = ($urandom_range(0, 15) != 0);
            {vid_rd, vid_burst, host_rd, host_wr, mem_op_begun, mem_data_ok} = 6'($urandom);
            vid_addr = AW'($urandom); host_addr = AW'($urandom); host_wdata = DW'($urandom);
            step();
            check_all("rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
